// File: rtl/fft_sequencer.sv
// ============================================================================
// Module   : fft_sequencer
// Brief    : Control sequencer for a LOG2N-stage radix-2 SDF FFT pipeline.
//            Optional macro FFT_SEQ_BITREV_EN: out_idx_o is the bit-reversed
//            output position (natural frequency order).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fft_sequencer #(
  parameter int LOG2N = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         valid_i,
  output logic                         ready_o,
  output logic                         en_o,
  output logic [LOG2N-1:0]             stage_mode_o,
  output logic [LOG2N*(LOG2N-1)-1:0]   tw_idx_o,
  output logic                         valid_o,
  output logic                         sop_o,
  output logic [LOG2N-1:0]             out_idx_o
);

  localparam int c_N    = 1 << LOG2N;
  localparam int c_TW_W = LOG2N - 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t           r_state;
  logic [LOG2N-1:0] r_cnt;
  logic [c_N-2:0]   r_tag;

  logic             w_drain;
  logic             w_accept;
  logic             w_cnt_zero;
  logic             w_cnt_last;
  logic [LOG2N-1:0] w_pos;

  assign w_drain    = (r_state == S_DRAIN);
  assign ready_o    = ~w_drain;
  assign en_o       = w_drain | valid_i;
  assign w_accept   = valid_i & ready_o;
  assign w_cnt_zero = (r_cnt == '0);
  assign w_cnt_last = (r_cnt == LOG2N'(c_N - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_tag   <= '0;
    end else begin
      if (en_o) begin
        r_cnt <= r_cnt + LOG2N'(1);
        r_tag <= {r_tag[c_N-3:0], w_accept};
      end
      case (r_state)
        S_IDLE: begin
          if (w_accept) r_state <= S_RUN;
        end
        S_RUN: begin
          // A frame boundary with no new data flushes only if samples are in flight.
          if (!valid_i) begin
            if (!w_cnt_zero)  r_state <= S_HOLD;
            else if (|r_tag)  r_state <= S_DRAIN;
            else              r_state <= S_IDLE;
          end
        end
        S_HOLD: begin
          if (w_accept) r_state <= S_RUN;
        end
        S_DRAIN: begin
          if (w_cnt_last) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign valid_o = en_o & r_tag[c_N-2];
  assign w_pos   = r_cnt + LOG2N'(1);
  assign sop_o   = valid_o & (w_pos == '0);

  // Only the low LOG2N-k bits of each stage's local count are ever observed.
  for (genvar k = 0; k < LOG2N; k++) begin : g_stage
    localparam logic [LOG2N-1:0] c_LAT = LOG2N'(c_N - (1 << (LOG2N - k)));
    logic [LOG2N-1-k:0] w_lc;

    assign w_lc            = r_cnt[LOG2N-1-k:0] - c_LAT[LOG2N-1-k:0];
    assign stage_mode_o[k] = w_lc[LOG2N-1-k];

    if (k < LOG2N - 1) begin : g_tw
      assign tw_idx_o[k*c_TW_W +: c_TW_W] = c_TW_W'(w_lc[LOG2N-2-k:0]) << k;
    end else begin : g_tw_zero
      assign tw_idx_o[k*c_TW_W +: c_TW_W] = '0;
    end
  end

`ifdef FFT_SEQ_BITREV_EN
  for (genvar i = 0; i < LOG2N; i++) begin : g_bitrev
    assign out_idx_o[i] = w_pos[LOG2N-1-i];
  end
`else
  assign out_idx_o = w_pos;
`endif

endmodule

`default_nettype wire
